// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> COMMIT over one shared req/ack
// memory port. Ends in sticky HALT (ecall/ebreak) or ERROR (illegal opcode or
// memory timeout); only rst_n leaves either.
// Optional feature: define CTRL_PERF_CNT_EN to add the cycle_cnt / instret_cnt ports.
module multicycle_ctrl #(
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ack,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [2:0]  state_o,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_COMMIT = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_SYS, C_BAD
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYS    = 7'h73;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    op_class_t        cls;

    // Classify the latched opcode once; every decision below uses the class.
    always_comb begin
        unique case (opcode_q)
            OP_R:      cls = C_R;
            OP_I:      cls = C_I;
            OP_LOAD:   cls = C_LOAD;
            OP_STORE:  cls = C_STORE;
            OP_BRANCH: cls = C_BRANCH;
            OP_JAL:    cls = C_JAL;
            OP_JALR:   cls = C_JALR;
            OP_LUI:    cls = C_LUI;
            OP_AUIPC:  cls = C_AUIPC;
            OP_SYS:    cls = C_SYS;
            default:   cls = C_BAD;
        endcase
    end

    // Next-state, opcode capture, memory timeout and sticky status flags.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d   = state_q;
        opcode_d  = opcode_q;
        tmo_cnt_d = '0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        unique case (state_q)
            S_FETCH, S_MEM: begin
                // Ack beats a timeout landing in the same cycle.
                if (mem_ack) begin
                    if (state_q == S_FETCH) begin
                        opcode_d = opcode;
                        state_d  = S_DECODE;
                    end else begin
                        state_d  = S_COMMIT;
                    end
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    state_d   = S_ERROR;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (cls == C_BAD) begin
                    state_d   = S_ERROR;
                    illegal_d = 1'b1;
                end else if (cls == C_SYS) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:   state_d = (cls inside {C_LOAD, C_STORE}) ? S_MEM : S_COMMIT;
            S_COMMIT: state_d = S_FETCH;
            S_HALT, S_ERROR: state_d = state_q;
            default:  state_d = S_ERROR;
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            tmo_cnt_q <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            tmo_cnt_q <= tmo_cnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Unregistered control decode from state, latched opcode and ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel_d = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        // NOTE: reset parks the FSM in FETCH, so the decode is gated by rst_n to keep
        // mem_req and ir_write low (and drop an in-flight request) while reset is held.
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ack;
                end
                S_EXEC, S_MEM: begin
                    alu_a_sel = (cls == C_AUIPC);
                    alu_b_sel = cls inside {C_I, C_LOAD, C_STORE, C_JALR, C_AUIPC};
                    if (state_q == S_MEM) begin
                        mem_req   = 1'b1;
                        mem_sel_d = 1'b1;
                        mem_we    = (cls == C_STORE);
                    end
                end
                S_COMMIT: begin
                    pc_write  = 1'b1;
                    reg_write = !(cls inside {C_STORE, C_BRANCH});
                    if (cls == C_JAL || (cls == C_BRANCH && branch_cond)) begin
                        pc_src = 2'd1;
                    end else if (cls == C_JALR) begin
                        pc_src = 2'd2;
                    end
                    if (cls == C_LOAD) begin
                        wb_sel = 2'd1;
                    end else if (cls inside {C_JAL, C_JALR}) begin
                        wb_sel = 2'd2;
                    end else if (cls == C_LUI) begin
                        wb_sel = 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    // Free-running cycle count in live states; retired-instruction count per COMMIT.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_HALT && state_q != S_ERROR) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (state_q == S_COMMIT) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4).
// Each cycle's expected control vector is queued when stimulus is driven and
// popped for comparison at the following falling edge.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_SYS   = 7'h73;
    localparam logic [6:0] OP_BAD   = 7'h7F;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       mem_sel_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic       halted;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;

    typedef struct {
        logic       ack;
        logic       bc;
        logic [6:0] op;
        ctrl_t      exp;
    } stim_t;

    localparam ctrl_t E_ZERO       = '0;
    localparam ctrl_t E_FETCH_WAIT = '{state: S_FETCH, mem_req: 1'b1, default: '0};
    localparam ctrl_t E_FETCH_ACK  = '{state: S_FETCH, mem_req: 1'b1, ir_write: 1'b1, default: '0};
    localparam ctrl_t E_DEC        = '{state: S_DECODE, default: '0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic        mem_ack = 1'b0;
    logic        branch_cond = 1'b0;
    logic        mem_req, mem_we, mem_sel_d, ir_write, pc_write, reg_write;
    logic        alu_a_sel, alu_b_sel, halted, illegal, bus_err;
    logic [1:0]  pc_src, wb_sel;
    logic [2:0]  state_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int    n_pass = 0;
    int    n_total = 0;
    int    n_commit = 0;
    ctrl_t sb[$];
    stim_t st_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.TMO_W(8), .MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ack    (mem_ack),
        .branch_cond(branch_cond),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_sel_d  (mem_sel_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .state_o    (state_o),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    function automatic ctrl_t observe();
        ctrl_t o;
        o.state     = state_o;
        o.mem_req   = mem_req;
        o.mem_we    = mem_we;
        o.mem_sel_d = mem_sel_d;
        o.ir_write  = ir_write;
        o.pc_write  = pc_write;
        o.pc_src    = pc_src;
        o.reg_write = reg_write;
        o.wb_sel    = wb_sel;
        o.alu_a_sel = alu_a_sel;
        o.alu_b_sel = alu_b_sel;
        o.halted    = halted;
        o.illegal   = illegal;
        o.bus_err   = bus_err;
        return o;
    endfunction

    function automatic stim_t mk(input logic ack, input logic bc, input logic [6:0] op, input ctrl_t e);
        stim_t s;
        s.ack = ack;
        s.bc  = bc;
        s.op  = op;
        s.exp = e;
        return s;
    endfunction

    // Queue one non-memory instruction with a 1-cycle fetch ack: FETCH, DECODE, EXEC, COMMIT.
    function automatic void add_simple(input logic [6:0] op, input logic bc, input logic a, input logic b,
                                       input logic [1:0] src, input logic rw, input logic [1:0] wb);
        st_q.push_back(mk(1'b1, bc, op, E_FETCH_ACK));
        st_q.push_back(mk(1'b0, bc, op, E_DEC));
        st_q.push_back(mk(1'b0, bc, op, '{state: S_EXEC, alu_a_sel: a, alu_b_sel: b, default: '0}));
        st_q.push_back(mk(1'b0, bc, op, '{state: S_COMMIT, pc_write: 1'b1, pc_src: src,
                                          reg_write: rw, wb_sel: wb, default: '0}));
        n_commit++;
    endfunction

    // Called at posedge+1: apply one cycle's inputs and queue its expected controls.
    task automatic drive(input stim_t s);
        mem_ack     = s.ack;
        branch_cond = s.bc;
        opcode      = s.op;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        ctrl_t got, exp;
        rst_n = 1'b0; mem_ack = 1'b1; opcode = OP_R;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sb.push_back(E_ZERO);
        got = observe(); exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL reset_hold: got %p expected %p", got, exp);
        else n_pass++;
`ifdef CTRL_PERF_CNT_EN
        n_total++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0)
            $display("FAIL reset_perf: got cycle %0d instret %0d expected 0 0", cycle_cnt, instret_cnt);
        else n_pass++;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(1'b0, 1'b0, OP_R, E_FETCH_WAIT));
        @(negedge clk);
        got = observe(); exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL reset_release: got %p expected %p", got, exp);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        st_q.delete();
        // Bus opcode turns garbage after fetch and ack wiggles outside FETCH/MEM: both ignored.
        st_q.push_back(mk(1'b1, 1'b0, OP_R, E_FETCH_ACK));
        st_q.push_back(mk(1'b1, 1'b0, OP_BAD, E_DEC));
        st_q.push_back(mk(1'b1, 1'b0, OP_BAD, '{state: S_EXEC, default: '0}));
        st_q.push_back(mk(1'b1, 1'b0, OP_BAD, '{state: S_COMMIT, pc_write: 1'b1, reg_write: 1'b1, default: '0}));
        n_commit++;
        foreach (st_q[i]) begin
            ctrl_t got, exp;
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL add[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        ctrl_t e_mem;
        e_mem = '{state: S_MEM, mem_req: 1'b1, mem_sel_d: 1'b1, alu_b_sel: 1'b1, default: '0};
        st_q.delete();
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, E_FETCH_WAIT));
        st_q.push_back(mk(1'b1, 1'b0, OP_LOAD, E_FETCH_ACK));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, E_DEC));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, '{state: S_EXEC, alu_b_sel: 1'b1, default: '0}));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, e_mem));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, e_mem));
        st_q.push_back(mk(1'b1, 1'b0, OP_LOAD, e_mem));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, '{state: S_COMMIT, pc_write: 1'b1, reg_write: 1'b1,
                                                 wb_sel: 2'd1, default: '0}));
        n_commit++;
        foreach (st_q[i]) begin
            ctrl_t got, exp;
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL load[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        st_q.delete();
        st_q.push_back(mk(1'b1, 1'b0, OP_STORE, E_FETCH_ACK));
        st_q.push_back(mk(1'b0, 1'b0, OP_STORE, E_DEC));
        st_q.push_back(mk(1'b0, 1'b0, OP_STORE, '{state: S_EXEC, alu_b_sel: 1'b1, default: '0}));
        st_q.push_back(mk(1'b1, 1'b0, OP_STORE, '{state: S_MEM, mem_req: 1'b1, mem_we: 1'b1,
                                                  mem_sel_d: 1'b1, alu_b_sel: 1'b1, default: '0}));
        st_q.push_back(mk(1'b0, 1'b0, OP_STORE, '{state: S_COMMIT, pc_write: 1'b1, default: '0}));
        n_commit++;
        foreach (st_q[i]) begin
            ctrl_t got, exp;
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL store[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_classes();
        st_q.delete();
        //          op        bc    a     b     pc_src rw    wb
        add_simple(OP_I,     1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
        add_simple(OP_BR,    1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0);
        add_simple(OP_BR,    1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        add_simple(OP_JAL,   1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2);
        add_simple(OP_JALR,  1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
        add_simple(OP_LUI,   1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        add_simple(OP_AUIPC, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
        foreach (st_q[i]) begin
            ctrl_t got, exp;
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL class[%0d] op=%h: got %p expected %p", i, st_q[i].op, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    // Ack arrives in the very cycle the timeout counter reaches its limit.
    task automatic test_ack_wins();
        st_q.delete();
        repeat (4) st_q.push_back(mk(1'b0, 1'b0, OP_I, E_FETCH_WAIT));
        add_simple(OP_I, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
        foreach (st_q[i]) begin
            ctrl_t got, exp;
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL ack_wins[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        ctrl_t got, exp;
        st_q.delete();
        st_q.push_back(mk(1'b1, 1'b0, OP_LOAD, E_FETCH_ACK));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, E_DEC));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, '{state: S_EXEC, alu_b_sel: 1'b1, default: '0}));
        st_q.push_back(mk(1'b0, 1'b0, OP_LOAD, '{state: S_MEM, mem_req: 1'b1, mem_sel_d: 1'b1,
                                                 alu_b_sel: 1'b1, default: '0}));
        foreach (st_q[i]) begin
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL mid_mem[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
`ifdef CTRL_PERF_CNT_EN
        n_total++;
        if (instret_cnt !== 32'(n_commit))
            $display("FAIL instret_count: got %0d expected %0d", instret_cnt, n_commit);
        else n_pass++;
`endif
        // Still in MEM with the request up; pull reset mid-cycle.
        rst_n = 1'b0;
        sb.push_back(E_ZERO);
        #1;
        got = observe(); exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL mid_mem_reset: got %p expected %p", got, exp);
        else n_pass++;
`ifdef CTRL_PERF_CNT_EN
        n_total++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0)
            $display("FAIL mid_mem_perf: got cycle %0d instret %0d expected 0 0", cycle_cnt, instret_cnt);
        else n_pass++;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(1'b0, 1'b0, OP_LOAD, E_FETCH_WAIT));
        @(negedge clk);
        got = observe(); exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL mid_mem_refetch: got %p expected %p", got, exp);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        ctrl_t got, exp;
        ctrl_t e_err;
        e_err = '{state: S_ERROR, illegal: 1'b1, default: '0};
        st_q.delete();
        st_q.push_back(mk(1'b1, 1'b0, OP_BAD, E_FETCH_ACK));
        st_q.push_back(mk(1'b0, 1'b0, OP_BAD, E_DEC));
        st_q.push_back(mk(1'b1, 1'b1, OP_R, e_err));
        st_q.push_back(mk(1'b1, 1'b1, OP_R, e_err));
        foreach (st_q[i]) begin
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL illegal[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        sb.push_back(E_ZERO);
        #1;
        got = observe(); exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL illegal_clear: got %p expected %p", got, exp);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        ctrl_t got, exp;
        ctrl_t e_halt;
        e_halt = '{state: S_HALT, halted: 1'b1, default: '0};
        st_q.delete();
        st_q.push_back(mk(1'b1, 1'b0, OP_SYS, E_FETCH_ACK));
        st_q.push_back(mk(1'b0, 1'b0, OP_SYS, E_DEC));
        st_q.push_back(mk(1'b1, 1'b0, OP_R, e_halt));
        st_q.push_back(mk(1'b1, 1'b0, OP_R, e_halt));
        foreach (st_q[i]) begin
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL halt[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        sb.push_back(E_ZERO);
        #1;
        got = observe(); exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL halt_clear: got %p expected %p", got, exp);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Fetch never acked: five request cycles (count 0..4), then ERROR with mem_req low.
    task automatic test_timeout();
        ctrl_t got, exp;
        ctrl_t e_err;
        e_err = '{state: S_ERROR, bus_err: 1'b1, default: '0};
        st_q.delete();
        repeat (5) st_q.push_back(mk(1'b0, 1'b0, OP_R, E_FETCH_WAIT));
        st_q.push_back(mk(1'b0, 1'b0, OP_R, e_err));
        st_q.push_back(mk(1'b1, 1'b0, OP_R, e_err));
        foreach (st_q[i]) begin
            drive(st_q[i]);
            @(negedge clk);
            got = observe(); exp = sb.pop_front(); n_total++;
            if (got !== exp) $display("FAIL timeout[%0d]: got %p expected %p", i, got, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        sb.push_back(E_ZERO);
        #1;
        got = observe(); exp = sb.pop_front(); n_total++;
        if (got !== exp) $display("FAIL timeout_clear: got %p expected %p", got, exp);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_store();
        test_classes();
        test_ack_wins();
        test_reset_mid_mem();
        test_illegal();
        test_halt();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
